// File: rtl/write_ptr_ctrl_if.sv
// Write-side port bundle for the async FIFO write-pointer controller.
// master drives the request side, slave is the controller itself.
interface write_ptr_ctrl_if #(
  parameter int PTR_WIDTH = 3
);
  logic               w_en;
  logic               clr_ovf;
  logic [PTR_WIDTH:0] g_rptr;
  logic [PTR_WIDTH:0] b_wptr;
  logic [PTR_WIDTH:0] g_wptr;
  logic [PTR_WIDTH:0] wr_level;
  logic               full;
  logic               almost_full;
  logic               overflow;

  modport master (
    output w_en, clr_ovf, g_rptr,
    input  b_wptr, g_wptr, wr_level, full, almost_full, overflow
  );

  modport slave (
    input  w_en, clr_ovf, g_rptr,
    output b_wptr, g_wptr, wr_level, full, almost_full, overflow
  );
endinterface

// File: rtl/write_ptr_ctrl.sv
// Async FIFO write-domain pointer logic: binary/Gray write pointer, synchronized
// read pointer, registered full/almost_full/level and a sticky overflow flag.
module write_ptr_ctrl #(
  parameter int PTR_WIDTH   = 3,
  parameter int AFULL_LEVEL = 6
) (
  input  logic wclk,
  input  logic wrst_n,
  write_ptr_ctrl_if.slave bus
);
  localparam int W = PTR_WIDTH + 1;

  logic [W-1:0] sync1, sync2;
  logic [W-1:0] b_rsync, b_wnext, g_wnext, level_next, full_cmp;
  logic         accepted, ovf_set;

  assign accepted   = bus.w_en & ~bus.full;
  assign ovf_set    = bus.w_en & bus.full;
  assign b_wnext    = bus.b_wptr + W'(accepted);
  assign g_wnext    = b_wnext ^ (b_wnext >> 1);
  assign level_next = b_wnext - b_rsync;
  // Full when the write pointer is one lap ahead: top two Gray bits inverted.
  assign full_cmp   = sync2 ^ (W'(3) << (W - 2));

  always_comb begin
    b_rsync = '0;
    b_rsync[W-1] = sync2[W-1];
    for (int i = W - 2; i >= 0; i--)
      b_rsync[i] = b_rsync[i+1] ^ sync2[i];
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      sync1           <= '0;
      sync2           <= '0;
      bus.b_wptr      <= '0;
      bus.g_wptr      <= '0;
      bus.wr_level    <= '0;
      bus.full        <= 1'b0;
      bus.almost_full <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      sync1           <= bus.g_rptr;
      sync2           <= sync1;
      bus.b_wptr      <= b_wnext;
      bus.g_wptr      <= g_wnext;
      bus.full        <= (g_wnext == full_cmp);
      bus.wr_level    <= level_next;
      bus.almost_full <= (level_next >= W'(AFULL_LEVEL));
      if (ovf_set)
        bus.overflow <= 1'b1;
      else if (bus.clr_ovf)
        bus.overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_write_ptr_ctrl.sv
// Bench for write_ptr_ctrl: occupancy-based reference model checked every cycle,
// plus directed fill / overflow / drain / wrap / reset scenarios with literal values.
module tb_write_ptr_ctrl;
  localparam int PW = 3;
  localparam int W  = PW + 1;
  localparam int D  = 1 << PW;
  localparam int M  = 1 << W;
  localparam int AF = 6;

  logic wclk = 1'b0;
  logic wrst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   cmp_en = 1'b0;

  write_ptr_ctrl_if #(.PTR_WIDTH(PW)) bus ();
  write_ptr_ctrl #(.PTR_WIDTH(PW), .AFULL_LEVEL(AF)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .bus(bus)
  );

  always #5 wclk = ~wclk;

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) % M;
  endfunction

  function automatic int ungray(input int g);
    int b = g;
    for (int s = 1; s < W; s++) b ^= (g >> s);
    return b % M;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: write count and occupancy against a read position that
  // becomes visible two write-clock edges after it is presented.
  int m_wp, m_lvl, m_r1, m_r2;
  bit m_full, m_af, m_ovf;

  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      m_wp = 0; m_lvl = 0; m_r1 = 0; m_r2 = 0;
      m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      bit set_ovf;
      set_ovf = bus.w_en && m_full;
      if (bus.w_en && !m_full) m_wp = (m_wp + 1) % M;
      m_lvl  = (m_wp - m_r2 + M) % M;
      m_full = (m_lvl == D);
      m_af   = (m_lvl >= AF);
      if (set_ovf) m_ovf = 1;
      else if (bus.clr_ovf) m_ovf = 0;
      m_r2 = m_r1;
      m_r1 = ungray(int'(bus.g_rptr));
    end
  end

  always @(negedge wclk) begin
    if (wrst_n && cmp_en) begin
      chk("b_wptr", int'(bus.b_wptr), m_wp);
      chk("g_wptr", int'(bus.g_wptr), gray(m_wp));
      chk("wr_level", int'(bus.wr_level), m_lvl);
      chk("full", int'(bus.full), int'(m_full));
      chk("almost_full", int'(bus.almost_full), int'(m_af));
      chk("overflow", int'(bus.overflow), int'(m_ovf));
    end
  end

  task automatic edge1();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_b_wptr"}, int'(bus.b_wptr), 0);
    chk({tag, "_g_wptr"}, int'(bus.g_wptr), 0);
    chk({tag, "_wr_level"}, int'(bus.wr_level), 0);
    chk({tag, "_full"}, int'(bus.full), 0);
    chk({tag, "_almost_full"}, int'(bus.almost_full), 0);
    chk({tag, "_overflow"}, int'(bus.overflow), 0);
  endtask

  task automatic do_reset();
    #2 wrst_n = 1'b0;
    #1 chk_zero("rst");
    @(negedge wclk);
    #2 wrst_n = 1'b1;
  endtask

  initial begin
    int rp, wp, rate;
    bus.w_en = 0; bus.clr_ovf = 0; bus.g_rptr = '0;
    #3 chk_zero("por");
    @(negedge wclk);
    #2 wrst_n = 1'b1;
    cmp_en = 1'b1;

    // Fill with read pointer parked at 0.
    for (int i = 1; i <= 8; i++) begin
      bus.w_en = 1;
      edge1();
      if (i == 5) chk("fill_af5", int'(bus.almost_full), 0);
      if (i == 6) chk("fill_af6", int'(bus.almost_full), 1);
      if (i == 7) chk("fill_full7", int'(bus.full), 0);
    end
    chk("fill_full", int'(bus.full), 1);
    chk("fill_b_wptr", int'(bus.b_wptr), 8);
    chk("fill_g_wptr", int'(bus.g_wptr), 12);
    chk("fill_level", int'(bus.wr_level), 8);

    // Write while full.
    edge1();
    chk("ovf_b_wptr", int'(bus.b_wptr), 8);
    chk("ovf_set", int'(bus.overflow), 1);
    bus.w_en = 0; bus.clr_ovf = 1;
    edge1();
    chk("ovf_clr", int'(bus.overflow), 0);
    bus.w_en = 1;
    edge1();
    chk("ovf_set_wins", int'(bus.overflow), 1);
    chk("ovf_b_wptr2", int'(bus.b_wptr), 8);
    bus.w_en = 0;
    edge1();
    chk("ovf_clr2", int'(bus.overflow), 0);
    bus.clr_ovf = 0;

    // Drain: read pointer jumps to 8; visible only two edges later.
    bus.g_rptr = 4'b1100;
    edge1();
    chk("drain_k_full", int'(bus.full), 1);
    chk("drain_k_level", int'(bus.wr_level), 8);
    edge1();
    chk("drain_k1_full", int'(bus.full), 1);
    chk("drain_k1_level", int'(bus.wr_level), 8);
    edge1();
    chk("drain_k2_full", int'(bus.full), 0);
    chk("drain_k2_level", int'(bus.wr_level), 0);

    // Wrap with the reader trailing one entry behind.
    do_reset();
    wp = 0;
    for (int i = 0; i < 16; i++) begin
      bus.g_rptr = W'(gray((wp - 1 + M) % M));
      bus.w_en = 1;
      edge1();
      wp = (wp + 1) % M;
      chk("wrap_nofull", int'(bus.full), 0);
      if (i == 14) begin
        chk("wrap_b15", int'(bus.b_wptr), 15);
        chk("wrap_g15", int'(bus.g_wptr), 8);
      end
    end
    chk("wrap_b0", int'(bus.b_wptr), 0);
    chk("wrap_g0", int'(bus.g_wptr), 0);

    // Mid-burst asynchronous reset, then write on the first edge after release.
    bus.w_en = 1;
    edge1();
    do_reset();
    edge1();
    chk("post_rst_write", int'(bus.b_wptr), 1);

    // Randomized traffic with bursty reader.
    rp = 0; bus.g_rptr = '0; rate = 1;
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) rate = $urandom_range(0, 3);
      if (c == 300) begin
        do_reset();
        rp = 0;
      end
      bus.w_en    = ($urandom_range(0, 3) != 0);
      bus.clr_ovf = ($urandom_range(0, 15) == 0);
      if (rp != m_wp && $urandom_range(0, 3) < rate) rp = (rp + 1) % M;
      bus.g_rptr = W'(gray(rp));
      edge1();
    end

    bus.w_en = 0; bus.clr_ovf = 0;
    edge1();
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/write_ptr_ctrl.md
WRITE_PTR_CTRL -- requirements
Module: write_ptr_ctrl

Interface
REQ-001 The block SHALL have parameter PTR_WIDTH, default 3: address bits; FIFO depth = 2**PTR_WIDTH.
REQ-002 The block SHALL have parameter AFULL_LEVEL, default 6: occupancy at or above which almost_full asserts; legal range 1..2**PTR_WIDTH.
REQ-003 The block SHALL have port wclk, input, 1 bit: write-domain clock; all state on rising edge.
REQ-004 The block SHALL have port wrst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port w_en, input, 1 bit: write request.
REQ-006 The block SHALL have port g_rptr, input, PTR_WIDTH+1 bits: Gray read pointer from the read domain, asynchronous to wclk.
REQ-007 The block SHALL have port clr_ovf, input, 1 bit: clears the overflow flag.
REQ-008 The block SHALL have port b_wptr, output, PTR_WIDTH+1 bits: binary write pointer, registered; low PTR_WIDTH bits address memory.
REQ-009 The block SHALL have port g_wptr, output, PTR_WIDTH+1 bits: Gray write pointer, registered, for the read-domain synchronizer.
REQ-010 The block SHALL have port full, output, 1 bit: registered full flag; gates memory writes.
REQ-011 The block SHALL have port almost_full, output, 1 bit: registered occupancy >= AFULL_LEVEL.
REQ-012 The block SHALL have port wr_level, output, PTR_WIDTH+1 bits: registered occupancy as seen from the write domain, 0..2**PTR_WIDTH.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky flag for a write attempted while full.

Function
REQ-014 The block SHALL pass g_rptr through a two-flop synchronizer (sync1 -> sync2) clocked by wclk; only sync2 feeds downstream logic.
REQ-015 The block SHALL define a write as accepted when w_en=1 and full=0.
REQ-016 The block SHALL compute b_wnext = b_wptr + accepted, modulo 2**(PTR_WIDTH+1) with natural wrap, and g_wnext = b_wnext ^ (b_wnext >> 1).
REQ-017 The block SHALL register b_wptr <= b_wnext and g_wptr <= g_wnext every edge; a rejected write leaves both unchanged.
REQ-018 The block SHALL register full <= (g_wnext == {~sync2[MSB:MSB-1], sync2[MSB-2:0]}), so full asserts on the same edge as the write that fills the FIFO.
REQ-019 The block SHALL convert sync2 to binary b_rsync (prefix XOR from the MSB) and register wr_level <= b_wnext - b_rsync, modulo 2**(PTR_WIDTH+1).
REQ-020 The block SHALL register almost_full <= (b_wnext - b_rsync) >= AFULL_LEVEL on the same edge as wr_level.
REQ-021 The block SHALL set overflow on any edge where w_en=1 and full=1, and clear it on an edge where clr_ovf=1 with no set condition; set SHALL win over clear when both occur.
REQ-022 After g_rptr changes before edge k, full, almost_full and wr_level SHALL reflect the new value after edge k+2; write-side deassertion of full is therefore pessimistic and delayed.
REQ-023 The block SHALL never advance b_wptr while full=1, regardless of w_en.

Reset
REQ-024 While wrst_n=0, the block SHALL immediately force b_wptr, g_wptr, sync1, sync2, wr_level to 0 and full, almost_full, overflow to 0, independent of wclk.
REQ-025 After wrst_n deasserts, the block SHALL accept a write on the first rising edge; reset mid-operation discards all pointer and flag state.

Verification
REQ-026 The bench SHALL cover reset: wrst_n=0 mid-burst between edges -> all outputs 0 without a clock edge.
REQ-027 The bench SHALL cover fill: g_rptr=0, 8 consecutive writes -> after the 6th edge almost_full=1; after the 8th edge full=1, b_wptr=4'b1000, g_wptr=4'b1100, wr_level=8.
REQ-028 The bench SHALL cover overflow: when full, w_en=1 for one cycle -> b_wptr stays 4'b1000, overflow=1; then clr_ovf=1 with w_en=0 -> overflow=0.
REQ-029 The bench SHALL cover simultaneous overflow and clear: full, w_en=1 and clr_ovf=1 on the same edge -> overflow=1.
REQ-030 The bench SHALL cover drain: full; g_rptr driven to 4'b1100 (read pointer 8) before edge k -> full=0 and wr_level=0 after edge k+2, not earlier.
REQ-031 The bench SHALL cover wrap: 16 writes with g_rptr tracking gray(b_wptr-1) -> b_wptr wraps 4'b1111->4'b0000, g_wptr 4'b1000->4'b0000, full never asserted.
